// File: rtl/jt1943_romarb.sv
// jt1943_romarb: three-client ROM read arbiter in front of a 16-bit SDRAM
// controller. Each grant fetches two consecutive 16-bit words, low word
// first, and assembles them into a shared 32-bit dout. The winning client
// gets a one-cycle weN strobe only if it is still asking for the same address
// when the data arrives.
// Optional feature: define JT1943_ROMARB_RR_EN for round-robin arbitration;
// otherwise a fixed 0>1>2 priority is used and no pointer register exists.
module jt1943_romarb #(
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          req2,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  output logic          we0,
  output logic          we1,
  output logic          we2,
  output logic [31:0]   dout,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [15:0]   sdram_din
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_ACK = 3'd1;
  localparam logic [2:0] WORD0    = 3'd2;
  localparam logic [2:0] WORD1    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [1:0]    gnt_q;
  logic [AW-1:0] addr_q;
  logic          req_q;
  logic [31:0]   dout_q;

  logic          any_req;
  logic [1:0]    sel;
  logic [AW-1:0] sel_addr;
  logic [AW-1:0] gnt_addr;
  logic          gnt_req;
  logic          hit;

`ifdef JT1943_ROMARB_RR_EN
  // ptr_q holds the client the next search starts from
  logic [1:0] ptr_q;

  // Round-robin pick: search rotates starting at ptr_q
  always_comb begin
    sel = 2'd0;
    case (ptr_q)
      2'd1: begin
        if (req1)      sel = 2'd1;
        else if (req2) sel = 2'd2;
        else           sel = 2'd0;
      end
      2'd2: begin
        if (req2)      sel = 2'd2;
        else if (req0) sel = 2'd0;
        else           sel = 2'd1;
      end
      default: begin
        if (req0)      sel = 2'd0;
        else if (req1) sel = 2'd1;
        else           sel = 2'd2;
      end
    endcase
  end

  // Advance the search start past the client just granted (2 wraps to 0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else if (state_q == IDLE && any_req) begin
      ptr_q <= (sel == 2'd2) ? 2'd0 : 2'(sel + 2'd1);
    end
  end
`else
  // Fixed priority pick: client 0 beats 1 beats 2
  always_comb begin
    sel = 2'd0;
    if (req0)      sel = 2'd0;
    else if (req1) sel = 2'd1;
    else           sel = 2'd2;
  end
`endif

  assign any_req = req0 | req1 | req2;

  // Address of the client being granted this cycle
  always_comb begin
    sel_addr = addr0;
    case (sel)
      2'd1:    sel_addr = addr1;
      2'd2:    sel_addr = addr2;
      default: sel_addr = addr0;
    endcase
  end

  // Live request/address of the client that owns the transaction in flight
  always_comb begin
    gnt_addr = addr0;
    gnt_req  = req0;
    case (gnt_q)
      2'd1: begin
        gnt_addr = addr1;
        gnt_req  = req1;
      end
      2'd2: begin
        gnt_addr = addr2;
        gnt_req  = req2;
      end
      default: begin
        gnt_addr = addr0;
        gnt_req  = req0;
      end
    endcase
  end

  // Next-state logic; ack and rdy only matter in the states that expect them
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (any_req)   state_d = WAIT_ACK;
      WAIT_ACK: if (sdram_ack) state_d = WORD0;
      WORD0:    if (sdram_rdy) state_d = WORD1;
      WORD1:    if (sdram_rdy) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // State, grant latch, SDRAM request and data assembly; reset abandons any
  // transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q  <= sel;
            addr_q <= sel_addr;
            req_q  <= 1'b1;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) req_q <= 1'b0;
        end
        WORD0: begin
          if (sdram_rdy) dout_q[15:0] <= sdram_din;
        end
        WORD1: begin
          if (sdram_rdy) dout_q[31:16] <= sdram_din;
        end
        default: ;
      endcase
    end
  end

  // Strobe the owner only if it still wants the very address that was fetched
  always_comb begin
    hit = (state_q == DONE) && gnt_req && (gnt_addr == addr_q);
    we0 = hit && (gnt_q == 2'd0);
    we1 = hit && (gnt_q == 2'd1);
    we2 = hit && (gnt_q == 2'd2);
  end

  assign dout       = dout_q;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule

// File: doc/jt1943_romarb.md
JT1943_ROMARB -- requirements
Module: jt1943_romarb

Interface
REQ-001 SHALL have parameter AW, default 22, meaning the width of the 16-bit-word ROM address.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have ports req0, req1, req2, input, 1 bit each: client read request, level-held by the client cache.
REQ-005 SHALL have ports addr0, addr1, addr2, input, AW bits each: client 16-bit-word address, bit 0 always zero (32-bit aligned).
REQ-006 SHALL have ports we0, we1, we2, output, 1 bit each: one-cycle strobe telling that client that dout holds its data.
REQ-007 SHALL have port dout, output, 32 bits: fetched data shared by all clients, low word first from SDRAM.
REQ-008 SHALL have port sdram_req, output, 1 bit: read request to the SDRAM controller.
REQ-009 SHALL have port sdram_addr, output, AW bits: read address, held stable while sdram_req is high.
REQ-010 SHALL have port sdram_ack, input, 1 bit: one-cycle request acceptance.
REQ-011 SHALL have port sdram_rdy, input, 1 bit: one-cycle strobe, sdram_din valid.
REQ-012 SHALL have port sdram_din, input, 16 bits: SDRAM read data, two consecutive rdy strobes per request.

Function
REQ-013 SHALL implement states IDLE, WAIT_ACK, WORD0, WORD1, DONE.
REQ-014 IDLE: when any reqN is high, SHALL latch grant index and addrN, assert sdram_req next cycle, enter WAIT_ACK; grant order fixed 0>1>2 unless REQ-025 applies.
REQ-015 WAIT_ACK: SHALL hold sdram_req and sdram_addr until the cycle sdram_ack is high, then drop sdram_req and enter WORD0.
REQ-016 WORD0: on sdram_rdy SHALL store sdram_din into dout[15:0] and enter WORD1.
REQ-017 WORD1: on sdram_rdy SHALL store sdram_din into dout[31:16] and enter DONE.
REQ-018 DONE: SHALL assert weN of the granted client for exactly one cycle if that client's current addrN equals the latched address and reqN is high, otherwise assert no we; SHALL return to IDLE on the same edge.
REQ-019 Minimum latency: reqN high at cycle 0 -> sdram_req at cycle 1 -> weN at cycle 1 + (ack, rdy, rdy cycles) + 1.
REQ-020 SHALL never assert more than one weN at a time, and SHALL never assert any weN outside DONE.
REQ-021 dout SHALL remain stable from DONE until the next WORD0 capture.
REQ-022 A client dropping reqN or changing addrN mid-transaction SHALL NOT abort the SDRAM access; the result is discarded per REQ-018.
REQ-023 sdram_rdy outside WORD0/WORD1 and sdram_ack outside WAIT_ACK SHALL be ignored.

Reset
REQ-024 While rst is high: state IDLE, sdram_req=0, sdram_addr=0, we0..we2=0, dout=0, priority pointer=client 0; a transaction in flight SHALL be abandoned with no we.

Configuration
REQ-025 With macro JT1943_ROMARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at the client after the last granted one (2 wraps to 0). Without it, fixed priority 0>1>2 applies and no pointer register exists.

Verification
REQ-026 req0=1, addr0=0x00010, ack after 2 cycles, rdy with 0x1234 then 0x5678 -> sdram_addr=0x00010, dout=0x56781234, we0 one cycle, we1=we2=0.
REQ-027 req0=req1=req2=1 held, fixed priority -> grants 0,0,0... ; with JT1943_ROMARB_RR_EN -> grants 0,1,2,0.
REQ-028 req1=1 addr1=0x00100, addr1 changed to 0x00104 before second rdy -> no we1; a new access to 0x00104 follows.
REQ-029 rst pulsed while in WORD1 -> all outputs 0 immediately, no we, next req restarts from IDLE.
REQ-030 Spurious sdram_rdy while in IDLE and WAIT_ACK -> dout unchanged, no state change.
